msg_sequencer: RTL and testbench

- Parametrised seven-segment message player for the piano front panel.
- Steps through NUM_PAGES pages of NUM_DIGITS 4-bit letter codes.
- Each page is held for DWELL_CYCLES, and pages are separated by GAP_CYCLES of blank display.
- Can be aborted by the stop key or by any note switch.
- Drives the existing sevenSeg decoder instances, one per digit; this block does no 7-segment decoding.

---
 rtl/msg_sequencer.sv | 168 ++++++++++++++++
 tb/tb_msg_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_sequencer.sv
// msg_sequencer: steps through NUM_PAGES pages of NUM_DIGITS letter codes and
// feeds them to the downstream seven-segment decoders. Each page is shown for
// DWELL_CYCLES, and pages are separated by GAP_CYCLES of blank display.
// Playback is aborted by the stop key, by a note switch, or by dropping play.
// Optional build macro: MSG_SEQ_LOOP_EN. When it is defined, playback wraps
// from the last page back to page 0 for as long as play stays high.
module msg_sequencer #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned NUM_PAGES    = 3,
  parameter int unsigned NUM_SW       = 7,
  parameter int unsigned DWELL_CYCLES = 100000000,
  parameter int unsigned GAP_CYCLES   = 1,
  parameter logic [3:0]  BLANK_CODE   = 4'd8,
  parameter logic [NUM_PAGES*NUM_DIGITS*4-1:0] PAGE_DATA =
    {4'd7, 4'd6, 4'd5, 4'd4, 4'd8, 4'd8, 4'd8, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0},
  localparam int unsigned PAGE_W = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    play,
  input  logic                    stop_n,
  input  logic [NUM_SW-1:0]       note_sw,
  output logic [NUM_DIGITS*4-1:0] digit_codes,
  output logic [PAGE_W-1:0]       page_idx,
  output logic                    busy,
  output logic                    done_pulse
);

  localparam int unsigned DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int unsigned GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned PAGE_BITS = NUM_DIGITS * 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SHOW = 3'd1,
    S_GAP  = 3'd2,
    S_DONE = 3'd3,
    S_STOP = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [PAGE_W-1:0]    page_q, page_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 play_q;
  logic [PAGE_BITS-1:0] codes_q, codes_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic play_rise;
  logic note_any;
  logic last_page;
  logic dwell_end;
  logic gap_end;

  assign play_rise = play & ~play_q;
  assign note_any  = |note_sw;
  assign last_page = (page_q == PAGE_W'(NUM_PAGES - 1));
  assign dwell_end = (dwell_q == DWELL_W'(DWELL_CYCLES - 1));
  assign gap_end   = (gap_q == GAP_W'(GAP_CYCLES - 1));

  // Next state, page and counters; counters fall back to zero unless the
  // state holds, so every state entry starts from a cleared count.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    dwell_d = '0;
    gap_d   = '0;
    if (state_q == S_STOP) begin
      if (note_any) begin
        state_d = S_IDLE;
        page_d  = '0;
      end
    end else if (!stop_n) begin
      state_d = S_STOP;
      page_d  = '0;
    end else if (note_any) begin
      state_d = S_IDLE;
      page_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          page_d = '0;
          if (play_rise) begin
            state_d = S_SHOW;
          end
        end
        S_SHOW: begin
          if (!play) begin
            state_d = S_DONE;
          end else if (dwell_end) begin
`ifdef MSG_SEQ_LOOP_EN
            state_d = S_GAP;
`else
            state_d = last_page ? S_DONE : S_GAP;
`endif
          end else begin
            dwell_d = dwell_q + DWELL_W'(1);
          end
        end
        S_GAP: begin
          if (gap_end) begin
            state_d = S_SHOW;
`ifdef MSG_SEQ_LOOP_EN
            page_d  = last_page ? '0 : page_q + PAGE_W'(1);
`else
            page_d  = page_q + PAGE_W'(1);
`endif
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          page_d  = '0;
        end
        default: begin
          state_d = S_IDLE;
          page_d  = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with state_q
  // without an extra cycle of latency.
  always_comb begin
    codes_d = {NUM_DIGITS{BLANK_CODE}};
    busy_d  = (state_d == S_SHOW) || (state_d == S_GAP);
    done_d  = (state_d == S_DONE);
    if (state_d == S_SHOW) begin
      for (int unsigned p = 0; p < NUM_PAGES; p++) begin
        if (page_d == PAGE_W'(p)) begin
          codes_d = PAGE_DATA[p*PAGE_BITS +: PAGE_BITS];
        end
      end
    end
  end

  // State, counters, play edge history and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      page_q  <= '0;
      dwell_q <= '0;
      gap_q   <= '0;
      play_q  <= 1'b0;
      codes_q <= {NUM_DIGITS{BLANK_CODE}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      dwell_q <= dwell_d;
      gap_q   <= gap_d;
      play_q  <= play;
      codes_q <= codes_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign digit_codes = codes_q;
  assign page_idx    = page_q;
  assign busy        = busy_q;
  assign done_pulse  = done_q;

endmodule

// File: tb/tb_msg_sequencer.sv
// Testbench for msg_sequencer: randomized and directed stimulus, expected
// outputs from a timeline-based reference model queued per cycle and checked
// by an independent monitor.
module tb_msg_sequencer;

  localparam int unsigned ND = 4;
  localparam int unsigned NP = 3;
  localparam int unsigned NSW = 7;
  localparam int unsigned D = 4;
  localparam int unsigned G = 2;
  localparam logic [47:0] PD =
    {4'd7, 4'd6, 4'd5, 4'd4, 4'd8, 4'd8, 4'd8, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0};
  localparam logic [15:0] BLANK = 16'h8888;
`ifdef MSG_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  // Timeline of one playback: page p occupies [p*PERIOD, p*PERIOD+D),
  // the gap after it the following G cycles.
  localparam int PERIOD   = D + G;
  localparam int RUN_LEN  = NP * PERIOD - G;
  localparam int LOOP_LEN = NP * PERIOD;

  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_DONE = 2;
  localparam int M_STOP = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           play;
  logic           stop_n;
  logic [NSW-1:0] note_sw;
  logic [15:0]    digit_codes;
  logic [1:0]     page_idx;
  logic           busy;
  logic           done_pulse;

  always #5 clk = ~clk;

  msg_sequencer #(
    .NUM_DIGITS  (ND),
    .NUM_PAGES   (NP),
    .NUM_SW      (NSW),
    .DWELL_CYCLES(D),
    .GAP_CYCLES  (G),
    .BLANK_CODE  (4'd8),
    .PAGE_DATA   (PD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .play       (play),
    .stop_n     (stop_n),
    .note_sw    (note_sw),
    .digit_codes(digit_codes),
    .page_idx   (page_idx),
    .busy       (busy),
    .done_pulse (done_pulse)
  );

  typedef struct packed {
    logic [15:0] codes;
    logic [1:0]  page;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int m_mode = M_IDLE;
  int m_t = 0;
  int m_last = 0;
  bit m_prev_play = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  task automatic model_step(input bit p, input bit s_n, input logic [NSW-1:0] n, input bit r);
    bit rise;
    int pos;
    if (!r) begin
      m_mode = M_IDLE;
      m_t = 0;
      m_last = 0;
      m_prev_play = 1'b0;
    end else begin
      rise = p && !m_prev_play;
      if (m_mode == M_STOP) begin
        if (n != '0) m_mode = M_IDLE;
      end else if (!s_n) begin
        m_mode = M_STOP;
      end else if (n != '0) begin
        m_mode = M_IDLE;
      end else begin
        case (m_mode)
          M_IDLE: if (rise) begin
            m_mode = M_PLAY;
            m_t = 0;
          end
          M_PLAY: begin
            pos = m_t % PERIOD;
            if (pos < int'(D) && !p) begin
              m_mode = M_DONE;
              m_last = m_t / PERIOD;
            end else begin
              m_t++;
              if (LOOP) begin
                if (m_t == LOOP_LEN) m_t = 0;
              end else if (m_t == RUN_LEN) begin
                m_mode = M_DONE;
                m_last = NP - 1;
              end
            end
          end
          default: m_mode = M_IDLE;
        endcase
      end
      m_prev_play = p;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int pg;
    e.codes = BLANK;
    e.page = 2'd0;
    e.busy = 1'b0;
    e.done = 1'b0;
    if (m_mode == M_DONE) begin
      e.page = 2'(m_last);
      e.done = 1'b1;
    end else if (m_mode == M_PLAY) begin
      pg = m_t / PERIOD;
      e.page = 2'(pg);
      e.busy = 1'b1;
      if ((m_t % PERIOD) < int'(D)) e.codes = 16'(PD >> (pg * 16));
    end
    return e;
  endfunction

  // Apply one cycle of inputs and queue the expected response for the next edge.
  task automatic cycle(input bit p, input bit s_n, input logic [NSW-1:0] n, input bit r);
    @(negedge clk);
    play = p;
    stop_n = s_n;
    note_sw = n;
    rst = r;
    model_step(p, s_n, n, r);
    exp_q.push_back(model_out());
    if (!r) begin
      #1;
      check("async_rst_codes", 32'(digit_codes), 32'(BLANK));
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_done", 32'(done_pulse), 32'd0);
      check("async_rst_page", 32'(page_idx), 32'd0);
    end
  endtask

  // Monitor: compare each registered output update against the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("digit_codes", 32'(digit_codes), 32'(e.codes));
      check("page_idx", 32'(page_idx), 32'(e.page));
      check("busy", 32'(busy), 32'(e.busy));
      check("done_pulse", 32'(done_pulse), 32'(e.done));
    end
  end

  initial begin
    logic [NSW-1:0] n;
    bit p;
    rst = 1'b0;
    play = 1'b0;
    stop_n = 1'b1;
    note_sw = '0;

    repeat (3) cycle(0, 1, '0, 0);
    repeat (2) cycle(0, 1, '0, 1);

    // Normal run with play held, then no retrigger while still high
    repeat (26) cycle(1, 1, '0, 1);
    repeat (2) cycle(0, 1, '0, 1);

    // Abort by dropping play during page 1
    repeat (8) cycle(1, 1, '0, 1);
    repeat (3) cycle(0, 1, '0, 1);

    // Stop key during a gap; play toggles ignored; note switch releases
    repeat (5) cycle(1, 1, '0, 1);
    cycle(1, 0, '0, 1);
    cycle(0, 1, '0, 1);
    cycle(1, 1, '0, 1);
    cycle(0, 0, '0, 1);
    cycle(1, 1, '0, 1);
    cycle(1, 1, 7'b0000100, 1);
    cycle(0, 1, '0, 1);
    repeat (3) cycle(1, 1, '0, 1);
    repeat (2) cycle(0, 1, '0, 1);

    // Note switch beats play_rise in IDLE; stop beats note switch
    cycle(1, 1, 7'h10, 1);
    repeat (2) cycle(1, 1, '0, 1);
    cycle(0, 1, '0, 1);
    cycle(1, 0, 7'h01, 1);
    cycle(0, 1, 7'h01, 1);
    cycle(0, 1, '0, 1);

    // Reset during page 2 with play held through release
    repeat (14) cycle(1, 1, '0, 1);
    repeat (2) cycle(1, 1, '0, 0);
    repeat (8) cycle(1, 1, '0, 1);
    repeat (2) cycle(0, 1, '0, 1);

    // Long hold: loops when the wrap feature is built in
    repeat (45) cycle(1, 1, '0, 1);
    repeat (3) cycle(0, 1, '0, 1);

    // Randomized traffic
    p = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) p = ~p;
      n = ($urandom_range(0, 59) == 0) ? NSW'($urandom) : '0;
      cycle(p, $urandom_range(0, 99) != 0, n, $urandom_range(0, 399) != 0);
    end

    repeat (3) cycle(0, 1, '0, 1);
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
